// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// tracks memory waits, counts retired instructions and latches trap causes.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          ENABLE_JUMP = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             cond_true,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             branch,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             illegal,
  output logic             bus_err
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TimeoutEn = (MEM_TIMEOUT != 0);
  localparam logic [WaitW-1:0] WaitLast = (MEM_TIMEOUT == 0) ? '0 : WaitW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StUpper, StAluWb, StBranch, StJal, StJalr, StLink, StTrap
  } state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              illegal_q, bus_err_q;
  logic              trap_ill, trap_bus, in_wait, retire;
  logic              pc_w, ir_w, reg_w, mem_r, mem_w;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    trap_ill   = 1'b0;
    trap_bus   = 1'b0;
    in_wait    = 1'b0;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    branch     = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_r      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = StDecode;
        end else begin
          in_wait = 1'b1;
        end
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBr:            state_d = StBranch;
          OpLui, OpAuipc:  state_d = StUpper;
          OpJal: begin
            if (ENABLE_JUMP) state_d = StJal;
            else begin
              state_d  = StTrap;
              trap_ill = 1'b1;
            end
          end
          OpJalr: begin
            if (ENABLE_JUMP) state_d = StJalr;
            else begin
              state_d  = StTrap;
              trap_ill = 1'b1;
            end
          end
          default: begin
            state_d  = StTrap;
            trap_ill = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_r   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = StMemWb;
        else           in_wait = 1'b1;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_w   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = StFetch;
        else           in_wait = 1'b1;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StUpper: begin
        // LUI adds the immediate to zero, AUIPC to the instruction's own PC
        alu_src_a = (opcode == OpLui) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_w   = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_w      = cond_true;
        state_d   = StFetch;
      end
      StJal: begin
        pc_w      = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = StAluWb;
      end
      StJalr: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w       = 1'b1;
        state_d    = StLink;
      end
      StLink: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = StAluWb;
      end
      StTrap: state_d = StTrap;
      default: state_d = StTrap;
    endcase

    // A ready in the final allowed wait cycle still completes the access
    if (in_wait) begin
      if (TimeoutEn && (wait_q == WaitLast)) begin
        state_d  = StTrap;
        trap_bus = 1'b1;
      end else begin
        wait_d = wait_q + WaitW'(1);
      end
    end
  end

  assign retire = (state_d == StFetch) && (state_q != StFetch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire)   cnt_q     <= cnt_q + CNT_W'(1);
      if (trap_ill) illegal_q <= 1'b1;
      if (trap_bus) bus_err_q <= 1'b1;
    end
  end

  assign pc_write      = pc_w & ~rst;
  assign ir_write      = ir_w & ~rst;
  assign reg_write     = reg_w & ~rst;
  assign mem_read      = mem_r & ~rst;
  assign mem_write     = mem_w & ~rst;
  assign instr_retired = retire & ~rst;
  assign retired_count = cnt_q;
  assign illegal       = illegal_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues expected retire records,
// a negedge monitor pops and compares them on each instr_retired pulse.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       mem_ready;
  logic       cond_true = 1'b0;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       branch, instr_retired, illegal, bus_err;
  logic [3:0] retired_count;

  logic       pc_write2, ir_write2, reg_write2, mem_read2, mem_write2, adr_src2;
  logic [1:0] alu_src_a2, alu_src_b2, alu_op2, result_src2;
  logic       branch2, instr_retired2, illegal2, bus_err2;
  logic [31:0] retired_count2;

  int fetch_waits = 0;
  int data_waits  = 0;
  int wcnt        = 0;
  int checks      = 0;
  int errors      = 0;

  typedef struct packed {
    int         lat;
    logic       rw;
    logic       mw;
    logic       pw;
    logic [1:0] rs;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_cnt = 4'd0;
  logic [9:0] probe_now;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(16), .ENABLE_JUMP(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .cond_true(cond_true),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .branch(branch), .instr_retired(instr_retired),
    .retired_count(retired_count), .illegal(illegal), .bus_err(bus_err)
  );

  multicycle_control #(.MEM_TIMEOUT(16), .ENABLE_JUMP(1'b0), .CNT_W(32)) dut_nojump (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .cond_true(cond_true),
    .pc_write(pc_write2), .ir_write(ir_write2), .reg_write(reg_write2), .mem_read(mem_read2),
    .mem_write(mem_write2), .adr_src(adr_src2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .alu_op(alu_op2), .result_src(result_src2), .branch(branch2),
    .instr_retired(instr_retired2), .retired_count(retired_count2), .illegal(illegal2),
    .bus_err(bus_err2)
  );

  // Memory model: ready after a configured number of wait cycles per request
  always_comb begin
    mem_ready = (mem_read || mem_write) && (wcnt >= (adr_src ? data_waits : fetch_waits));
  end

  always @(posedge clk) begin
    if ((mem_read || mem_write) && !mem_ready) wcnt <= wcnt + 1;
    else                                       wcnt <= 0;
  end

  assign probe_now = {ir_write, pc_write, result_src, alu_src_a, alu_src_b, alu_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency measured from the first FETCH cycle to the retire cycle
  int lat = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat = 0;
    end else begin
      lat++;
      if (instr_retired) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got retire with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk("latency", lat, e.lat);
          chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
          chk("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
          chk("pc_write", {31'd0, pc_write}, {31'd0, e.pw});
          chk("result_src", {30'd0, result_src}, {30'd0, e.rs});
          chk("count", {28'd0, retired_count}, {28'd0, e.cnt});
        end
        lat = 0;
      end
    end
  end

  // Called at posedge+1 of the first FETCH cycle; returns at posedge+1 after retire
  task automatic issue(input logic [6:0] op, input logic c, input int fw, input int dw,
                       input int exp_lat, input logic rw, input logic mw, input logic pw,
                       input logic [1:0] rs, input int pcyc, input logic [9:0] pexp);
    exp_t e;
    bit   done = 0;
    e.lat = exp_lat; e.rw = rw; e.mw = mw; e.pw = pw; e.rs = rs; e.cnt = exp_cnt;
    exp_cnt = exp_cnt + 4'd1;
    sb.push_back(e);
    opcode = op; cond_true = c; fetch_waits = fw; data_waits = dw;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == pcyc) chk("probe", {22'd0, probe_now}, {22'd0, pexp});
      if (instr_retired) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout: no retire within 200 cycles, opcode %b", op);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {26'd0, pc_write, ir_write, reg_write, mem_read, mem_write,
        instr_retired}, 32'd0);
    chk("reset_flags", {29'd0, illegal, bus_err, illegal2}, 32'd0);
    chk("reset_count", {28'd0, retired_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 4'd0;
  endtask

  initial begin
    int n, early, bad;
    do_reset();

    issue(OpJal,   1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 3, 10'b0_1_00_01_10_00);
    chk("nojump_illegal", {30'd0, illegal2, bus_err2}, 32'h2);
    issue(OpR,     1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 1, 10'b1_1_10_00_10_00);
    issue(OpLoad,  1'b0, 0, 3, 8, 1'b1, 1'b0, 1'b0, 2'b01, 2, 10'b0_0_00_01_01_00);
    issue(OpStore, 1'b0, 0, 0, 4, 1'b0, 1'b1, 1'b0, 2'b00, 3, 10'b0_0_00_10_01_00);
    issue(OpBr,    1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b1, 2'b00, 3, 10'b0_1_00_10_00_01);
    issue(OpBr,    1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 2'b00, 3, 10'b0_0_00_10_00_01);
    issue(OpI,     1'b0, 2, 0, 6, 1'b1, 1'b0, 1'b0, 2'b00, 5, 10'b0_0_00_10_01_10);
    issue(OpLui,   1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 3, 10'b0_0_00_11_01_00);
    issue(OpAuipc, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 3, 10'b0_0_00_01_01_00);
    issue(OpJalr,  1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b0, 2'b00, 3, 10'b0_1_10_10_01_00);
    for (int k = 0; k < 6; k++) begin
      issue(OpR, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 3, 10'b0_0_00_10_00_10);
    end
    chk("count_wrap", {28'd0, retired_count}, 32'd0);

    // Fetch never ready: 16 wait cycles then bus error trap
    opcode = OpR; fetch_waits = 1000;
    n = 0; early = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_read) break;
      n++;
      if (bus_err) early++;
    end
    chk("fetch_wait_cycles", n, 16);
    chk("bus_err_early", early, 0);
    chk("bus_err_flags", {30'd0, bus_err, illegal}, 32'h2);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (pc_write || ir_write || reg_write || mem_read || mem_write || instr_retired) bad++;
    end
    chk("trap_quiet", bad, 0);
    @(posedge clk);
    #1;
    fetch_waits = 0;
    do_reset();

    // Illegal opcode traps from DECODE
    opcode = 7'b1111111;
    repeat (4) @(negedge clk);
    chk("illegal_flags", {30'd0, illegal, bus_err}, 32'h2);
    chk("illegal_quiet", {30'd0, mem_read, reg_write}, 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of a load aborts it without a retire
    opcode = OpLoad; data_waits = 5;
    repeat (5) @(negedge clk);
    chk("abort_memread", {30'd0, mem_read, adr_src}, 32'h3);
    @(posedge clk);
    #1;
    do_reset();
    data_waits = 0;
    chk("abort_sb_empty", sb.size(), 0);

    issue(OpR, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 2'b00, 3, 10'b0_0_00_10_00_10);
    chk("final_count", {28'd0, retired_count}, 32'd1);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
